// File: rtl/mips_mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers and a BUSY/DONE handshake.
// Optional build macro MDU_EARLY_TERM_EN: multiplies leave CALC once the remaining multiplier is zero.
module mips_mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [1:0]            OP,
  input  logic [DATA_WIDTH-1:0] SRC_A,
  input  logic [DATA_WIDTH-1:0] SRC_B,
  input  logic                  HI_WE,
  input  logic                  LO_WE,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DIV_BY_ZERO,
  output logic [DATA_WIDTH-1:0] HI_OUT,
  output logic [DATA_WIDTH-1:0] LO_OUT
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic            is_div_r, sign_r, rem_neg_r, dbz_r;
  logic [2*W-1:0]  acc_r, mcand_r;
  logic [W-1:0]    mplier_r;
  logic [CW-1:0]   cnt_r;
  logic [W-1:0]    hi_r, lo_r;
  logic            busy_r, done_r, dbz_out_r;

  logic            signed_op_s, a_neg_s, b_neg_s, b_zero_s, last_s, cnt_last_s;
  logic [W-1:0]    a_mag_s, b_mag_s;
  logic [2*W-1:0]  mul_acc_s, prod_s;
  logic [W:0]      rem_shift_s, diff_s;
  logic [W-1:0]    div_hi_s, div_lo_s, quo_s, rem_s, res_hi_s, res_lo_s;

  // Launch-time operand conditioning: magnitudes and sign flags.
  always_comb begin
    signed_op_s = ~OP[0];
    a_neg_s     = signed_op_s & SRC_A[W-1];
    b_neg_s     = signed_op_s & SRC_B[W-1];
    b_zero_s    = (SRC_B == {W{1'b0}});
    if (a_neg_s) a_mag_s = -SRC_A; else a_mag_s = SRC_A;
    if (b_neg_s) b_mag_s = -SRC_B; else b_mag_s = SRC_B;
  end

  // End-of-CALC detection; the early-exit build also watches the remaining multiplier.
  always_comb begin
    cnt_last_s = (cnt_r == CW'(W - 1));
`ifdef MDU_EARLY_TERM_EN
    if (is_div_r) last_s = cnt_last_s;
    else          last_s = cnt_last_s || (mplier_r[W-1:1] == {(W-1){1'b0}});
`else
    last_s = cnt_last_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (START) begin
          if (OP[1] && b_zero_s) state_s = S_FIX;
          else                   state_s = S_CALC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CALC: begin
        if (last_s) state_s = S_FIX;
        else        state_s = S_CALC;
      end
      S_FIX:   state_s = S_DONE;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // One iteration step: the multiplicand is shifted left so partial products stay aligned.
  always_comb begin
    if (mplier_r[0]) mul_acc_s = acc_r + mcand_r;
    else             mul_acc_s = acc_r;
    rem_shift_s = {acc_r[2*W-1:W], acc_r[W-1]};
    diff_s      = rem_shift_s - {1'b0, mcand_r[W-1:0]};
    if (!diff_s[W]) begin
      div_hi_s = diff_s[W-1:0];
      div_lo_s = {acc_r[W-2:0], 1'b1};
    end else begin
      div_hi_s = rem_shift_s[W-1:0];
      div_lo_s = {acc_r[W-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection for the FIX->DONE load.
  always_comb begin
    if (sign_r) prod_s = -acc_r;            else prod_s = acc_r;
    if (sign_r) quo_s  = -acc_r[W-1:0];     else quo_s  = acc_r[W-1:0];
    if (rem_neg_r) rem_s = -acc_r[2*W-1:W]; else rem_s  = acc_r[2*W-1:W];
    if (dbz_r) begin
      res_hi_s = acc_r[W-1:0];
      res_lo_s = {W{1'b1}};
    end else if (is_div_r) begin
      res_hi_s = rem_s;
      res_lo_s = quo_s;
    end else begin
      res_hi_s = prod_s[2*W-1:W];
      res_lo_s = prod_s[W-1:0];
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_r <= S_IDLE;
    else      state_r <= state_s;
  end

  // Operand capture and iteration datapath; a zero divisor keeps the raw dividend for HI.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      is_div_r  <= 1'b0;
      sign_r    <= 1'b0;
      rem_neg_r <= 1'b0;
      dbz_r     <= 1'b0;
      acc_r     <= {(2*W){1'b0}};
      mcand_r   <= {(2*W){1'b0}};
      mplier_r  <= {W{1'b0}};
      cnt_r     <= {CW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (START) begin
            is_div_r  <= OP[1];
            sign_r    <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            dbz_r     <= OP[1] & b_zero_s;
            cnt_r     <= {CW{1'b0}};
            if (OP[1]) begin
              acc_r    <= {{W{1'b0}}, (b_zero_s ? SRC_A : a_mag_s)};
              mcand_r  <= {{W{1'b0}}, b_mag_s};
              mplier_r <= {W{1'b0}};
            end else begin
              acc_r    <= {(2*W){1'b0}};
              mcand_r  <= {{W{1'b0}}, a_mag_s};
              mplier_r <= b_mag_s;
            end
          end
        end
        S_CALC: begin
          cnt_r <= cnt_r + CW'(1);
          if (is_div_r) begin
            acc_r <= {div_hi_s, div_lo_s};
          end else begin
            acc_r    <= mul_acc_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // HI/LO: result load on FIX->DONE, MTHI/MTLO only in an idle cycle with no launch.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_r <= {W{1'b0}};
      lo_r <= {W{1'b0}};
    end else if (state_r == S_FIX) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if ((state_r == S_IDLE) && !START) begin
      if (HI_WE) hi_r <= WR_DATA;
      if (LO_WE) lo_r <= WR_DATA;
    end
  end

  // Handshake outputs registered from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
    end else begin
      busy_r    <= (state_s == S_CALC) || (state_s == S_FIX);
      done_r    <= (state_s == S_DONE);
      dbz_out_r <= (state_s == S_DONE) && dbz_r;
    end
  end

  assign BUSY        = busy_r;
  assign DONE        = done_r;
  assign DIV_BY_ZERO = dbz_out_r;
  assign HI_OUT      = hi_r;
  assign LO_OUT      = lo_r;

endmodule

// File: tb/tb_mips_mul_div_unit.sv
// Randomized self-checking bench for mips_mul_div_unit against an arithmetic reference model.
module tb_mips_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wr_data;
  logic        hi_we, lo_we;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] prev_hi = 32'h0;
  logic [31:0] prev_lo = 32'h0;

  mips_mul_div_unit #(.DATA_WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .START(start), .OP(op), .SRC_A(src_a), .SRC_B(src_b),
    .HI_WE(hi_we), .LO_WE(lo_we), .WR_DATA(wr_data), .BUSY(busy), .DONE(done),
    .DIV_BY_ZERO(div_by_zero), .HI_OUT(hi_out), .LO_OUT(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full-precision arithmetic, truncating division, documented corner cases.
  task automatic model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output logic dbz, output int lat);
    longint      qa, qb, q, r;
    logic [63:0] p;
    logic [31:0] mag;
    int          bits;
    dbz = 1'b0;
    lat = 33;
    if (!mop[1]) begin
      if (mop == 2'd0) p = longint'($signed(a)) * longint'($signed(b));
      else             p = {32'h0, a} * {32'h0, b};
      hi = p[63:32];
      lo = p[31:0];
`ifdef MDU_EARLY_TERM_EN
      mag  = (mop == 2'd0 && b[31]) ? (32'h0 - b) : b;
      bits = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
      lat = ((bits == 0) ? 1 : bits) + 1;
`else
      mag  = b;
      bits = 0;
`endif
    end else if (b == 32'h0) begin
      hi = a; lo = 32'hFFFF_FFFF; dbz = 1'b1; lat = 1;
    end else begin
      if (mop == 2'd2) begin
        qa = longint'($signed(a)); qb = longint'($signed(b));
      end else begin
        qa = longint'({32'h0, a}); qb = longint'({32'h0, b});
      end
      q = qa / qb;
      r = qa % qb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Launch one operation, watch handshake and HI/LO hold, then check results.
  task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input bit we_at_start);
    logic [31:0] ehi, elo;
    logic        edbz;
    int          elat, lat, busy_cnt;
    bit          seen;
    model(mop, a, b, ehi, elo, edbz, elat);
    start = 1'b1; op = mop; src_a = a; src_b = b;
    if (we_at_start) begin lo_we = 1'b1; wr_data = $urandom; end
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    if (we_at_start) check_eq("we_dropped_at_start", {32'h0, lo_out}, {32'h0, prev_lo});
    busy_cnt = busy ? 1 : 0;
    seen = 1'b0; lat = 0;
    for (int n = 1; n <= 100 && !seen; n++) begin
      if (inject && elat > 6 && n == 5) begin
        start = 1'b1; hi_we = 1'b1; wr_data = 32'h1234;
      end
      if (n == 6) begin start = 1'b0; hi_we = 1'b0; end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1; lat = n;
      end else begin
        if (busy) busy_cnt++;
        check_eq("hold_prev", {hi_out, lo_out}, {prev_hi, prev_lo});
      end
    end
    start = 1'b0; hi_we = 1'b0;
    check_eq("latency", 64'(lat), 64'(elat));
    check_eq("busy_cycles", 64'(busy_cnt), 64'(elat));
    check_eq("result", {hi_out, lo_out}, {ehi, elo});
    check_eq("div_by_zero", {63'h0, div_by_zero}, {63'h0, edbz});
    @(posedge clk); #1;
    check_eq("done_pulse", {62'h0, done, busy}, 64'h0);
    check_eq("idle_hold", {hi_out, lo_out}, {ehi, elo});
    prev_hi = ehi; prev_lo = elo;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0000_0000;
      1: pick = 32'h0000_0001;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($urandom_range(0, 15));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'd0; src_a = 32'h0; src_b = 32'h0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", {29'h0, busy, done, div_by_zero, hi_out}, 64'h0);
    check_eq("reset_lo", {32'h0, lo_out}, 64'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run_op(2'd0, 32'hFFFF_FFFE, 32'h3, 1'b1, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b1, 1'b0);
    run_op(2'd3, 32'h7, 32'h2, 1'b0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'd3, 32'h5, 32'h0, 1'b0, 1'b0);
    run_op(2'd2, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
    run_op(2'd1, 32'h5, 32'h3, 1'b0, 1'b0);
    run_op(2'd1, 32'h1234_5678, 32'h0, 1'b0, 1'b1);

    // MTHI / MTLO / both.
    hi_we = 1'b1; wr_data = 32'hCAFE_0001;
    @(posedge clk); #1; hi_we = 1'b0;
    check_eq("mthi", {hi_out, lo_out}, {32'hCAFE_0001, prev_lo});
    prev_hi = 32'hCAFE_0001;
    lo_we = 1'b1; wr_data = 32'h1234;
    @(posedge clk); #1; lo_we = 1'b0;
    check_eq("mtlo", {hi_out, lo_out}, {prev_hi, 32'h1234});
    prev_lo = 32'h1234;
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h5A5A_A5A5;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    check_eq("mthi_mtlo", {hi_out, lo_out}, {32'h5A5A_A5A5, 32'h5A5A_A5A5});
    prev_hi = 32'h5A5A_A5A5; prev_lo = 32'h5A5A_A5A5;

    // Randomized operations.
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom), pick(), pick(), 1'($urandom), 1'($urandom_range(0, 3) == 0));

    // Reset in the middle of a multiply aborts it.
    begin
      bit saw_done;
      start = 1'b1; op = 2'd0; src_a = 32'h0000_0003; src_b = 32'h0000_0007;
      @(posedge clk); #1; start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_eq("abort_state", {30'h0, busy, done, hi_out}, 64'h0);
      check_eq("abort_lo", {32'h0, lo_out}, 64'h0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done || busy) saw_done = 1'b1;
      end
      check_eq("no_done_after_abort", {63'h0, saw_done}, 64'h0);
      prev_hi = 32'h0; prev_lo = 32'h0;
    end
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
